// File: rtl/ballot_unit.sv
// Voting-booth front end: synchronises and debounces four candidate buttons and
// turns one armed ballot into a single valid-vote or spoil strobe.
module ballot_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       arm,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       btn3,
  input  logic       btn4,
  output logic       vv1,
  output logic       vv2,
  output logic       vv3,
  output logic       vv4,
  output logic       spoil,
  output logic       ready,
  output logic [7:0] ballots
);

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_REL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       btn_raw;
  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       db;
  logic [3:0]       db_prev;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       rise;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] vote_d;
  logic [3:0] vote_q;
  logic       spoil_d;
  logic       spoil_q;
  logic       count_d;

  assign btn_raw = {btn4, btn3, btn2, btn1};

  // Stage p0/p1: two-flop synchroniser, then per-button debounce counter
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      db_prev <= db;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync_p1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = db & ~db_prev;

  // Ballot FSM: a press counts only if it is the sole button down in ARMED
  always_comb begin
    state_d = state_q;
    vote_d  = '0;
    spoil_d = 1'b0;
    count_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (rise != 4'b0000) begin
          state_d = WAIT_REL;
          if ($onehot(rise) && (db == rise)) begin
            vote_d  = rise;
            count_d = 1'b1;
          end else begin
            spoil_d = 1'b1;
          end
        end
      end
      WAIT_REL: begin
        if (db == 4'b0000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (mode) begin
      state_d = IDLE;
      vote_d  = '0;
      spoil_d = 1'b0;
      count_d = 1'b0;
    end
  end

  // Stage p2: registered strobes and ballot tally
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      vote_q  <= '0;
      spoil_q <= 1'b0;
      ballots <= '0;
    end else begin
      state_q <= state_d;
      vote_q  <= vote_d;
      spoil_q <= spoil_d;
      ballots <= ballots + {7'd0, count_d};
    end
  end

  assign vv1   = vote_q[0];
  assign vv2   = vote_q[1];
  assign vv3   = vote_q[2];
  assign vv4   = vote_q[3];
  assign spoil = spoil_q;
  assign ready = (state_q == ARMED);

endmodule
